// File: rtl/uart_rx_if.sv
// Bus bundle for the UART receiver: serial line and frame config in, byte and status out.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  RX_IN;
  logic                  parity_enable;
  logic                  parity_type;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  busy;

  modport master (
    output RX_IN, parity_enable, parity_type,
    input  P_DATA, data_valid, par_err, stp_err, busy
  );

  modport slave (
    input  RX_IN, parity_enable, parity_type,
    output P_DATA, data_valid, par_err, stp_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, PRESCALE-times oversampling with 3-sample majority,
// 8N1 frame with optional even/odd parity, one-cycle valid/error pulses.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input logic      CLK,
  input logic      RST,
  uart_rx_if.slave bus
);
  localparam int EW = $clog2(PRESCALE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [EW-1:0] EC_LAST = EW'(PRESCALE - 1);
  localparam logic [EW-1:0] SMP0    = EW'(PRESCALE / 2 - 1);
  localparam logic [EW-1:0] SMP1    = EW'(PRESCALE / 2);
  localparam logic [EW-1:0] SMP2    = EW'(PRESCALE / 2 + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_nxt;
  logic                  sync1, rx_s;
  logic [1:0]            settle;
  logic                  armed;
  logic [EW-1:0]         edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  pen, ptype, par_bad;
  logic                  smp0, smp1, smp_q;
  logic                  start_det, bit_end, last_bit, maj, sample;

  always_comb begin
    start_det = (state == IDLE) && !rx_s && armed;
    bit_end   = (state != IDLE) && (edge_cnt == EC_LAST);
    last_bit  = (bit_cnt == BW'(DATA_WIDTH - 1));
    maj       = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);
    sample    = (edge_cnt == SMP2) ? maj : smp_q;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_det) state_nxt = START;
      START:   if (bit_end) state_nxt = sample ? IDLE : DATA;
      DATA:    if (bit_end && last_bit) state_nxt = pen ? PARITY : STOP;
      PARITY:  if (bit_end) state_nxt = STOP;
      STOP:    if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= IDLE;
      sync1          <= 1'b1;
      rx_s           <= 1'b1;
      settle         <= '0;
      armed          <= 1'b0;
      edge_cnt       <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      pen            <= 1'b0;
      ptype          <= 1'b0;
      par_bad        <= 1'b0;
      smp0           <= 1'b1;
      smp1           <= 1'b1;
      smp_q          <= 1'b1;
      bus.P_DATA     <= '0;
      bus.data_valid <= 1'b0;
      bus.par_err    <= 1'b0;
      bus.stp_err    <= 1'b0;
    end else begin
      state          <= state_nxt;
      sync1          <= bus.RX_IN;
      rx_s           <= sync1;
      settle         <= {settle[0], 1'b1};
      bus.data_valid <= 1'b0;
      bus.par_err    <= 1'b0;
      bus.stp_err    <= 1'b0;

      // Reset-value highs in the synchronizer must not arm detection; a frame ending
      // with the line low (break) disarms until the line is seen high again.
      if (rx_s && settle[1])
        armed <= 1'b1;
      else if (start_det || (state == STOP && bit_end && !sample))
        armed <= 1'b0;

      if (state == IDLE) begin
        edge_cnt <= start_det ? EW'(1) : '0;
        if (start_det) begin
          pen     <= bus.parity_enable;
          ptype   <= bus.parity_type;
          bit_cnt <= '0;
          par_bad <= 1'b0;
        end
      end else begin
        edge_cnt <= bit_end ? '0 : edge_cnt + EW'(1);
        if (edge_cnt == SMP0) smp0  <= rx_s;
        if (edge_cnt == SMP1) smp1  <= rx_s;
        if (edge_cnt == SMP2) smp_q <= maj;
        if (bit_end) begin
          case (state)
            DATA: begin
              shreg   <= {sample, shreg[DATA_WIDTH-1:1]};
              bit_cnt <= bit_cnt + BW'(1);
            end
            PARITY: par_bad <= (sample != ((^shreg) ^ ptype));
            STOP: begin
              bus.data_valid <= sample && !par_bad;
              bus.par_err    <= par_bad;
              bus.stp_err    <= !sample;
              if (sample && !par_bad) bus.P_DATA <= shreg;
            end
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven bit by bit, pulses/busy logged by cycle at negedge.
module tb_uart_rx;
  logic CLK = 1'b0;
  logic RST;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  uart_rx_if #(.DATA_WIDTH(8)) bus ();

  uart_rx #(.DATA_WIDTH(8), .PRESCALE(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  int dv_cyc[$];
  int dv_dat[$];
  int pe_cyc[$];
  int se_cyc[$];
  int busy_first, busy_last;

  always @(negedge CLK) begin
    if (bus.data_valid) begin
      dv_cyc.push_back(cyc);
      dv_dat.push_back(int'(bus.P_DATA));
    end
    if (bus.par_err) pe_cyc.push_back(cyc);
    if (bus.stp_err) se_cyc.push_back(cyc);
    if (bus.busy) begin
      if (busy_first < 0) busy_first = cyc;
      busy_last = cyc;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic clear_log();
    dv_cyc.delete();
    dv_dat.delete();
    pe_cyc.delete();
    se_cyc.delete();
    busy_first = -1;
    busy_last  = -1;
  endtask

  // Entered just after a rising edge; line holds b for n cycles.
  task automatic hold(input logic b, input int n);
    bus.RX_IN = b;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic with_par, input logic pbit,
                            input logic stop);
    hold(1'b0, 8);
    for (int i = 0; i < 8; i++) hold(d[i], 8);
    if (with_par) hold(pbit, 8);
    hold(stop, 8);
  endtask

  int t0;

  initial begin
    busy_first        = -1;
    busy_last         = -1;
    RST               = 1'b1;
    bus.RX_IN         = 1'b1;
    bus.parity_enable = 1'b0;
    bus.parity_type   = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_p_data", int'(bus.P_DATA), 0);
    check("rst_flags", int'({bus.data_valid, bus.par_err, bus.stp_err, bus.busy}), 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    hold(1'b1, 20);

    // Plain 8N1 frame, latency and busy window
    clear_log();
    t0 = cyc;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    hold(1'b1, 20);
    check("a5_dv_count", dv_cyc.size(), 1);
    if (dv_cyc.size() == 1) begin
      check("a5_dv_time", dv_cyc[0] - t0, 82);
      check("a5_data", dv_dat[0], 'hA5);
    end
    check("a5_errs", pe_cyc.size() + se_cyc.size(), 0);
    check("a5_busy_first", busy_first - t0, 3);
    check("a5_busy_last", busy_last - t0, 81);

    // Even parity 0x3C, parity bit 0
    clear_log();
    bus.parity_enable = 1'b1;
    bus.parity_type   = 1'b0;
    t0 = cyc;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    hold(1'b1, 20);
    check("even_dv_count", dv_cyc.size(), 1);
    if (dv_cyc.size() == 1) begin
      check("even_dv_time", dv_cyc[0] - t0, 90);
      check("even_data", dv_dat[0], 'h3C);
    end
    check("even_par_err", pe_cyc.size(), 0);

    // Odd parity 0x01, parity bit 0
    clear_log();
    bus.parity_type = 1'b1;
    t0 = cyc;
    send_frame(8'h01, 1'b1, 1'b0, 1'b1);
    hold(1'b1, 20);
    check("odd_dv_count", dv_cyc.size(), 1);
    if (dv_cyc.size() == 1) begin
      check("odd_dv_time", dv_cyc[0] - t0, 90);
      check("odd_data", dv_dat[0], 'h01);
    end

    // Odd parity, wrong parity bit
    clear_log();
    t0 = cyc;
    send_frame(8'h01, 1'b1, 1'b1, 1'b1);
    hold(1'b1, 20);
    check("perr_dv_count", dv_cyc.size(), 0);
    check("perr_count", pe_cyc.size(), 1);
    if (pe_cyc.size() == 1) check("perr_time", pe_cyc[0] - t0, 90);
    check("perr_stp_count", se_cyc.size(), 0);
    check("perr_p_data_kept", int'(bus.P_DATA), 'h01);

    // Stop bit 0 on 0x55, then line held low (break)
    clear_log();
    bus.parity_enable = 1'b0;
    t0 = cyc;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    hold(1'b0, 100);
    check("stp_count", se_cyc.size(), 1);
    if (se_cyc.size() == 1) check("stp_time", se_cyc[0] - t0, 82);
    check("stp_dv_count", dv_cyc.size(), 0);
    check("stp_par_count", pe_cyc.size(), 0);
    check("break_busy_last", busy_last - t0, 81);
    check("stp_p_data_kept", int'(bus.P_DATA), 'h01);
    hold(1'b1, 10);
    clear_log();
    t0 = cyc;
    send_frame(8'h66, 1'b0, 1'b0, 1'b1);
    hold(1'b1, 20);
    check("after_break_dv_count", dv_cyc.size(), 1);
    if (dv_cyc.size() == 1) check("after_break_data", dv_dat[0], 'h66);

    // Two-cycle glitch on an idle line
    clear_log();
    t0 = cyc;
    hold(1'b0, 2);
    hold(1'b1, 30);
    check("glitch_pulses", dv_cyc.size() + pe_cyc.size() + se_cyc.size(), 0);
    check("glitch_busy_first", busy_first - t0, 3);
    check("glitch_busy_last", busy_last - t0, 9);

    // Back-to-back frames with no idle gap
    clear_log();
    t0 = cyc;
    send_frame(8'h12, 1'b0, 1'b0, 1'b1);
    send_frame(8'h34, 1'b0, 1'b0, 1'b1);
    hold(1'b1, 20);
    check("b2b_dv_count", dv_cyc.size(), 2);
    if (dv_cyc.size() == 2) begin
      check("b2b_first_time", dv_cyc[0] - t0, 82);
      check("b2b_spacing", dv_cyc[1] - dv_cyc[0], 80);
      check("b2b_data0", dv_dat[0], 'h12);
      check("b2b_data1", dv_dat[1], 'h34);
    end

    // Reset during data bit 4 with the line low
    clear_log();
    t0 = cyc;
    hold(1'b0, 8);
    hold(1'b1, 32);
    hold(1'b0, 6);
    RST = 1'b1;
    hold(1'b0, 1);
    RST = 1'b0;
    @(negedge CLK);
    check("rst_mid_busy", int'(bus.busy), 0);
    check("rst_mid_p_data", int'(bus.P_DATA), 0);
    @(posedge CLK);
    #1;
    clear_log();
    hold(1'b0, 40);
    check("rst_low_no_busy", busy_first, -1);
    check("rst_low_pulses", dv_cyc.size() + pe_cyc.size() + se_cyc.size(), 0);
    hold(1'b1, 10);
    clear_log();
    t0 = cyc;
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
    hold(1'b1, 20);
    check("post_rst_dv_count", dv_cyc.size(), 1);
    if (dv_cyc.size() == 1) begin
      check("post_rst_time", dv_cyc[0] - t0, 82);
      check("post_rst_data", dv_dat[0], 'hC3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
